// File: rtl/multicycle_seq.sv
// Multicycle RISC-V style control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// memory-wait watchdog that drops into a sticky TRAP state.
module multicycle_seq #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic                  branch_taken,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  addr_sel,
    output logic                  ir_we,
    output logic                  reg_we,
    output logic                  pc_we,
    output logic                  pc_sel,
    output logic [2:0]            state,
    output logic                  trap,
    output logic [DATA_WIDTH-1:0] instret
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e                r_state;
    logic [6:0]            r_op;
    logic [WAIT_W-1:0]     r_wait;
    logic                  r_trap;
    logic [DATA_WIDTH-1:0] r_instret;

    logic w_supported;
    logic w_is_load;
    logic w_is_store;
    logic w_is_branch;
    logic w_is_jump;
    logic w_wait_expired;

    // Decode legality uses the live opcode; everything after DECODE uses r_op
    always_comb begin
        w_supported = 1'b0;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_supported = 1'b1;
            default:                           w_supported = 1'b0;
        endcase
    end

    assign w_is_load      = (r_op == OP_LOAD);
    assign w_is_store     = (r_op == OP_STORE);
    assign w_is_branch    = (r_op == OP_BRANCH);
    assign w_is_jump      = (r_op == OP_JAL) || (r_op == OP_JALR);
    assign w_wait_expired = (r_wait == TIMEOUT);

    // Strobes are pure decodes of the current state so they act in the same cycle
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                if (w_is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = w_is_store;
                pc_we    = mem_ready && w_is_store;
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                pc_sel = w_is_jump;
            end
            default: ;
        endcase
    end

    // Sequencer; a ready response in the expiry cycle still takes the normal path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_op      <= 7'd0;
            r_wait    <= '0;
            r_trap    <= 1'b0;
            r_instret <= '0;
        end else begin
            if (pc_we) begin
                r_instret <= r_instret + DATA_WIDTH'(1);
            end
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                        r_wait  <= '0;
                    end else if (w_wait_expired) begin
                        r_state <= S_TRAP;
                        r_wait  <= '0;
                        r_trap  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    r_op   <= op;
                    r_wait <= '0;
                    if (w_supported) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_wait <= '0;
                    if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                    end else if (w_is_branch) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_state <= w_is_load ? S_WB : S_FETCH;
                        r_wait  <= '0;
                    end else if (w_wait_expired) begin
                        r_state <= S_TRAP;
                        r_wait  <= '0;
                        r_trap  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
                S_TRAP: begin
                    r_trap <= 1'b1;
                    r_wait <= '0;
                end
                default: begin
                    r_state <= S_TRAP;
                    r_trap  <= 1'b1;
                    r_wait  <= '0;
                end
            endcase
        end
    end

    assign state   = r_state;
    assign trap    = r_trap;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: per-instruction expected traces built from the
// instruction-class rules, a directed vector table and randomized instructions.
module tb_multicycle_seq;

    localparam int unsigned DW   = 4;
    localparam int unsigned TO   = 4;
    localparam int          TO_I = int'(TO);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [6:0]    op = 7'd0;
    logic          branch_taken = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we, pc_sel;
    logic [2:0]    state;
    logic          trap;
    logic [DW-1:0] instret;
    logic [6:0]    strb;

    multicycle_seq #(.DATA_WIDTH(DW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .state(state), .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    assign strb = {mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we, pc_sel};

    typedef struct packed {
        logic [2:0] st;
        logic [6:0] strb;
        logic       rdy;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic       bt;
        int         fw;
        int         mw;
        int         len;
    } vec_t;

    cyc_t          trace[$];
    logic          m_end_trap;
    logic [DW-1:0] m_instret;
    int            n_checks = 0;
    int            n_err = 0;
    logic [6:0]    ops[9];
    vec_t          vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic cyc_t mk(input logic [2:0] st, input logic [6:0] s, input logic r);
        cyc_t c;
        c.st   = st;
        c.strb = s;
        c.rdy  = r;
        return c;
    endfunction

    function automatic logic supported(input logic [6:0] o);
        for (int i = 0; i < 9; i++) begin
            if (ops[i] == o) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Latency rule: branch 3, store 4, load 5, others 4, plus any wait cycles
    function automatic int model_len(input logic [6:0] o, input int fw, input int mw);
        if (o == OP_BR) return fw + 3;
        if (o == OP_LD) return fw + 5 + mw;
        if (o == OP_ST) return fw + 4 + mw;
        return fw + 4;
    endfunction

    // Expected per-cycle trace; a wait longer than TO cycles ends in TRAP
    task automatic build_trace(input logic [6:0] o, input logic bt, input int fw, input int mw);
        logic st_op;
        logic ldst;
        logic jmp;
        st_op = (o == OP_ST);
        ldst  = (o == OP_LD) || st_op;
        jmp   = (o == OP_JAL) || (o == OP_JR);
        trace.delete();
        m_end_trap = 1'b0;
        for (int i = 0; i < fw && i <= TO_I; i++) trace.push_back(mk(3'd0, 7'b1000000, 1'b0));
        if (fw > TO_I) begin
            m_end_trap = 1'b1;
            return;
        end
        trace.push_back(mk(3'd0, 7'b1001000, 1'b1));
        trace.push_back(mk(3'd1, 7'b0000000, 1'($urandom)));
        if (!supported(o)) begin
            m_end_trap = 1'b1;
            return;
        end
        if (o == OP_BR) begin
            trace.push_back(mk(3'd2, {6'b000001, bt}, 1'($urandom)));
            return;
        end
        trace.push_back(mk(3'd2, 7'b0000000, 1'($urandom)));
        if (ldst) begin
            for (int i = 0; i < mw && i <= TO_I; i++)
                trace.push_back(mk(3'd3, {1'b1, st_op, 1'b1, 4'b0000}, 1'b0));
            if (mw > TO_I) begin
                m_end_trap = 1'b1;
                return;
            end
            trace.push_back(mk(3'd3, {1'b1, st_op, 1'b1, 2'b00, st_op, 1'b0}, 1'b1));
            if (st_op) return;
        end
        trace.push_back(mk(3'd4, {4'b0000, 1'b1, 1'b1, jmp}, 1'($urandom)));
    endtask

    task automatic run_instr(input logic [6:0] o, input logic bt, input int fw, input int mw,
                             input int exp_len, input int abort_at);
        int lat;
        logic left;
        logic done;
        int dec_idx;
        build_trace(o, bt, fw, mw);
        lat = 0;
        left = 1'b0;
        done = 1'b0;
        dec_idx = (fw > TO_I) ? -1 : fw + 1;
        for (int i = 0; i < trace.size(); i++) begin
            if (abort_at >= 0 && i == abort_at) return;
            @(negedge clk);
            op = (i == dec_idx) ? o : 7'($urandom);
            branch_taken = (i == dec_idx + 1) ? bt : 1'($urandom);
            mem_ready = trace[i].rdy;
            #1;
            chk("state", 32'(state), 32'(trace[i].st));
            chk("strobes", 32'(strb), 32'(trace[i].strb));
            chk("instret", 32'(instret), 32'(m_instret));
            chk("trap_low", 32'(trap), 32'd0);
            if (trace[i].strb[1]) m_instret = m_instret + 1'b1;
            if (!done) begin
                if (left && state == 3'd0) done = 1'b1;
                else begin
                    lat++;
                    if (state != 3'd0) left = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("end_state", 32'(state), m_end_trap ? 32'd5 : 32'd0);
        chk("end_trap", 32'(trap), 32'(m_end_trap));
        chk("end_instret", 32'(instret), 32'(m_instret));
        if (!m_end_trap && exp_len > 0) chk("latency", 32'(lat), 32'(exp_len));
    endtask

    task automatic trap_hold();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = 7'($urandom);
            branch_taken = 1'($urandom);
            mem_ready = 1'($urandom);
            #1;
            chk("trap_state", 32'(state), 32'd5);
            chk("trap_flag", 32'(trap), 32'd1);
            chk("trap_strobes", 32'(strb), 32'd0);
            chk("trap_instret", 32'(instret), 32'(m_instret));
        end
    endtask

    // Asserts reset mid-cycle, checks it takes effect without a clock edge
    task automatic do_reset();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_strobes", 32'(strb), 32'h40);
        m_instret = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int fw;
        int mw;
        logic [6:0] o;
        logic bt;
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JR, OP_LUI, OP_AUI};
        vecs[0]  = '{OP_I,     1'b0, 0,      0,      4};
        vecs[1]  = '{OP_BR,    1'b1, 0,      0,      3};
        vecs[2]  = '{OP_BR,    1'b0, 0,      0,      3};
        vecs[3]  = '{OP_LD,    1'b0, 0,      0,      5};
        vecs[4]  = '{OP_LD,    1'b0, 0,      3,      8};
        vecs[5]  = '{OP_ST,    1'b0, 0,      0,      4};
        vecs[6]  = '{OP_R,     1'b1, 0,      0,      4};
        vecs[7]  = '{OP_JAL,   1'b0, 0,      0,      4};
        vecs[8]  = '{OP_JR,    1'b1, 1,      0,      5};
        vecs[9]  = '{OP_LUI,   1'b0, 2,      0,      6};
        vecs[10] = '{OP_AUI,   1'b0, 0,      0,      4};
        vecs[11] = '{OP_LD,    1'b0, TO_I,   TO_I,   13};
        vecs[12] = '{OP_ST,    1'b0, 0,      TO_I,   8};
        vecs[13] = '{7'h7F,    1'b0, 0,      0,      0};
        vecs[14] = '{OP_ST,    1'b0, 0,      TO_I+1, 0};
        vecs[15] = '{OP_LD,    1'b0, TO_I+1, 0,      0};
        m_instret = '0;
        #3;
        do_reset();

        for (int v = 0; v < 16; v++) begin
            run_instr(vecs[v].op, vecs[v].bt, vecs[v].fw, vecs[v].mw, vecs[v].len, -1);
            if (m_end_trap) begin
                trap_hold();
                do_reset();
            end
        end

        // Reset while a store is waiting in MEM: nothing retires
        for (int k = 0; k < 15; k++) run_instr(OP_I, 1'b0, 0, 0, 4, -1);
        chk("pre_all_ones", 32'(instret), 32'hF);
        run_instr(OP_ST, 1'b0, 0, 3, 0, 5);
        chk("mid_mem_state", 32'(state), 32'd3);
        do_reset();

        // Counter preloaded to all-ones wraps on the next retirement
        for (int k = 0; k < 15; k++) run_instr(OP_R, 1'b0, 0, 0, 4, -1);
        chk("all_ones", 32'(instret), 32'hF);
        run_instr(OP_ST, 1'b0, 0, 0, 4, -1);
        chk("wrap_zero", 32'(instret), 32'd0);

        for (int k = 0; k < 200; k++) begin
            o  = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            bt = 1'($urandom);
            fw = ($urandom_range(0, 19) == 0) ? TO_I + 1 : int'($urandom_range(0, TO));
            mw = ($urandom_range(0, 19) == 0) ? TO_I + 1 : int'($urandom_range(0, TO));
            run_instr(o, bt, fw, mw, model_len(o, fw, mw), -1);
            if (m_end_trap) begin
                trap_hold();
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
